// File: rtl/branch_target_predictor.sv
// -----------------------------------------------------------------------------
// branch_target_predictor
//
// Fetch-side branch predictor for the 5-stage MIPS pipeline. A direct-mapped
// branch target buffer (BTB) holds one 2-bit saturating counter and a target
// per entry. The current fetch PC is looked up combinationally every cycle,
// and branches resolved in decode train the table on the next clock edge.
// Mispredictions are flagged in the same cycle as the resolution so the
// hazard logic can flush and redirect fetch to pc_recover.
//
// Parameters:
//   ENTRIES  number of BTB entries (power of two, 2..256)
//
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   pcf               current fetch PC
//   bp_en             prediction enable (0 forces pre_br=0, training continues)
//   upd_valid         a conditional branch was resolved in decode this cycle
//   upd_pc            PC of the resolved branch
//   upd_taken         actual outcome
//   upd_target        actual target
//   upd_pred          pre_br value that travelled with the branch
//   upd_pred_target   pc_predict value that travelled with the branch
//   pre_br            predict taken for pcf
//   pc_predict        predicted next PC for pcf
//   mispredict        resolved branch disagrees with its prediction
//   pc_recover        correct next PC after a misprediction
//
// Optional feature (macro BTB_PERF_CNT_EN): adds the free-running 32-bit
// counters perf_branches, perf_mispred and perf_alloc.
// -----------------------------------------------------------------------------
module branch_target_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pcf,
  input  logic        bp_en,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred,
  input  logic [31:0] upd_pred_target,
  output logic        pre_br,
  output logic [31:0] pc_predict,
  output logic        mispredict,
  output logic [31:0] pc_recover
`ifdef BTB_PERF_CNT_EN
  ,
  output logic [31:0] perf_branches,
  output logic [31:0] perf_mispred,
  output logic [31:0] perf_alloc
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  // Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  logic [ENTRIES-1:0] r_valid;
  logic [1:0]         r_ctr    [ENTRIES];
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];

  // ---------------------------------------------------------------------------
  // Lookup (same cycle as pcf). Reset clears r_valid asynchronously, so a
  // lookup during reset always misses and falls through to pcf+4.
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic             w_lk_hit;

  assign w_lk_idx   = pcf[IDX_W+1:2];
  assign w_lk_tag   = pcf[31:IDX_W+2];
  assign w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign pre_br     = bp_en && w_lk_hit && r_ctr[w_lk_idx][1];
  assign pc_predict = w_lk_hit ? r_target[w_lk_idx] : (pcf + 32'd4);

  // ---------------------------------------------------------------------------
  // Resolution side: misprediction detection and recovery PC.
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_up_hit;
  logic             w_alloc;

  assign w_up_idx = upd_pc[IDX_W+1:2];
  assign w_up_tag = upd_pc[31:IDX_W+2];
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  assign w_alloc  = upd_valid && upd_taken && !w_up_hit;

  // A predicted-taken branch that went to a different target is still a miss.
  assign mispredict = rst_n && upd_valid &&
                      ((upd_taken != upd_pred) ||
                       (upd_taken && upd_pred && (upd_target != upd_pred_target)));
  assign pc_recover = upd_taken ? upd_target : (upd_pc + 32'd4);

  // ---------------------------------------------------------------------------
  // Training: valid bits and counters carry reset state.
  // ---------------------------------------------------------------------------
  // NOTE: all sequential state uses non-blocking assignments so every read in
  // this cycle (lookup and update) sees the pre-edge contents; that is what
  // gives read-before-write when lookup and update hit the same index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= CTR_WNT;
    end else if (upd_valid) begin
      if (w_up_hit) begin
        if (upd_taken) begin
          if (r_ctr[w_up_idx] != CTR_ST) r_ctr[w_up_idx] <= r_ctr[w_up_idx] + 2'd1;
        end else begin
          if (r_ctr[w_up_idx] != CTR_SNT) r_ctr[w_up_idx] <= r_ctr[w_up_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        r_valid[w_up_idx] <= 1'b1;
        r_ctr[w_up_idx]   <= CTR_WT;
      end
    end
  end

  // NOTE: tag and target arrays are deliberately left out of reset; a cleared
  // valid bit makes their contents irrelevant, and a write that lands while
  // reset is asserted is hidden the same way.
  always_ff @(posedge clk) begin
    if (upd_valid && upd_taken) begin
      r_tag[w_up_idx]    <= w_up_tag;
      r_target[w_up_idx] <= upd_target;
    end
  end

`ifdef BTB_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters, wrapping modulo 2^32.
  // ---------------------------------------------------------------------------
  logic [31:0] r_perf_branches;
  logic [31:0] r_perf_mispred;
  logic [31:0] r_perf_alloc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_branches <= '0;
      r_perf_mispred  <= '0;
      r_perf_alloc    <= '0;
    end else begin
      if (upd_valid)  r_perf_branches <= r_perf_branches + 32'd1;
      if (mispredict) r_perf_mispred  <= r_perf_mispred  + 32'd1;
      if (w_alloc)    r_perf_alloc    <= r_perf_alloc    + 32'd1;
    end
  end

  assign perf_branches = r_perf_branches;
  assign perf_mispred  = r_perf_mispred;
  assign perf_alloc    = r_perf_alloc;
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_target_predictor
//
// Directed, self-checking bench for branch_target_predictor (ENTRIES=16).
// Inputs change 1 ns after a rising edge; outputs are sampled a further 1 ns
// later, well away from the next rising edge. Define BTB_PERF_CNT_EN on both
// bench and RTL to also check the performance counters.
// -----------------------------------------------------------------------------
module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pcf;
  logic        bp_en;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred;
  logic [31:0] upd_pred_target;
  logic        pre_br;
  logic [31:0] pc_predict;
  logic        mispredict;
  logic [31:0] pc_recover;
`ifdef BTB_PERF_CNT_EN
  logic [31:0] perf_branches;
  logic [31:0] perf_mispred;
  logic [31:0] perf_alloc;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  branch_target_predictor #(.ENTRIES(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pcf             (pcf),
    .bp_en           (bp_en),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred        (upd_pred),
    .upd_pred_target (upd_pred_target),
    .pre_br          (pre_br),
    .pc_predict      (pc_predict),
    .mispredict      (mispredict),
    .pc_recover      (pc_recover)
`ifdef BTB_PERF_CNT_EN
    ,
    .perf_branches   (perf_branches),
    .perf_mispred    (perf_mispred),
    .perf_alloc      (perf_alloc)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic pr, input logic [31:0] ptgt);
    upd_valid       = v;
    upd_pc          = pc;
    upd_taken       = tk;
    upd_target      = tgt;
    upd_pred        = pr;
    upd_pred_target = ptgt;
  endtask

  task automatic idle();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    // ---------------- reset state ----------------
    rst_n = 1'b0;
    bp_en = 1'b1;
    pcf   = 32'h40;
    idle();
    #3;
    check("rst_pre_br", pre_br, 1'b0);
    check("rst_pc_predict", pc_predict, 32'h44);
    check("rst_mispredict_idle", mispredict, 1'b0);
    // A mismatching update during reset must neither flag nor train.
    set_upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    #1;
    check("rst_mispredict_gated", mispredict, 1'b0);
    @(posedge clk);
    #2;
    idle();
    rst_n = 1'b1;
    tick();

    // ---------------- cold lookup ----------------
    pcf = 32'h40;
    #1;
    check("cold_pre_br", pre_br, 1'b0);
    check("cold_pc_predict", pc_predict, 32'h44);
    check("cold_mispredict", mispredict, 1'b0);

    // ---------------- allocate 0x40 with same-cycle lookup ----------------
    set_upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    #1;
    check("alloc_mispredict", mispredict, 1'b1);
    check("alloc_pc_recover", pc_recover, 32'h100);
    check("rbw_pre_br", pre_br, 1'b0);
    check("rbw_pc_predict", pc_predict, 32'h44);
    tick();                                     // upd 1: mis, alloc
    idle();
    #1;
    check("trained_pre_br", pre_br, 1'b1);
    check("trained_pc_predict", pc_predict, 32'h100);
    bp_en = 1'b0;
    #1;
    check("bp_en0_pre_br", pre_br, 1'b0);
    bp_en = 1'b1;

    // ---------------- two not-taken updates: 10 -> 01 -> 00 ----------------
    tick();
    set_upd(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
    #1;
    check("nt1_mispredict", mispredict, 1'b1);
    check("nt1_pc_recover", pc_recover, 32'h44);
    tick();                                     // upd 2: mis
    idle();
    #1;
    check("nt1_pre_br", pre_br, 1'b0);
    check("nt1_still_hit", pc_predict, 32'h100);
    set_upd(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h44);
    #1;
    check("nt2_mispredict", mispredict, 1'b0);
    tick();                                     // upd 3
    idle();
    #1;
    check("nt2_pre_br", pre_br, 1'b0);
    check("nt2_still_valid", pc_predict, 32'h100);

    // ---------------- training with bp_en=0: 00 -> 01 -> 10 ----------------
    bp_en = 1'b0;
    set_upd(1'b1, 32'h40, 1'b1, 32'h200, 1'b0, 32'h44);
    #1;
    check("tk_bp0_mispredict", mispredict, 1'b1);
    tick();                                     // upd 4: mis
    idle();
    #1;
    check("tk_target_rewrite", pc_predict, 32'h200);
    set_upd(1'b1, 32'h40, 1'b1, 32'h200, 1'b0, 32'h44);
    tick();                                     // upd 5: mis
    idle();
    #1;
    check("bp0_trains_pre_br", pre_br, 1'b0);
    bp_en = 1'b1;
    #1;
    check("bp1_after_train", pre_br, 1'b1);

    // ---------------- saturation at 11, then two decrements ----------------
    set_upd(1'b1, 32'h40, 1'b1, 32'h200, 1'b1, 32'h200);
    #1;
    check("correct_mispredict", mispredict, 1'b0);
    tick();                                     // upd 6: 10 -> 11
    tick();                                     // upd 7: 11 stays 11
    set_upd(1'b1, 32'h40, 1'b1, 32'h200, 1'b1, 32'h300);
    #1;
    check("wrong_tgt_mispredict", mispredict, 1'b1);
    check("wrong_tgt_recover", pc_recover, 32'h200);
    set_upd(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h200);
    tick();                                     // upd 8: mis, 11 -> 10
    idle();
    #1;
    check("sat_dec1_pre_br", pre_br, 1'b1);
    set_upd(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h200);
    tick();                                     // upd 9: mis, 10 -> 01
    idle();
    #1;
    check("sat_dec2_pre_br", pre_br, 1'b0);

    // ---------------- aliasing: 0x80 shares index 0 with 0x40 ----------------
    set_upd(1'b1, 32'h80, 1'b1, 32'h500, 1'b0, 32'h84);
    #1;
    check("alias_pc_recover", pc_recover, 32'h500);
    tick();                                     // upd 10: mis, alloc
    idle();
    pcf = 32'h40;
    #1;
    check("alias_old_pre_br", pre_br, 1'b0);
    check("alias_old_pc_predict", pc_predict, 32'h44);
    pcf = 32'h80;
    #1;
    check("alias_new_pre_br", pre_br, 1'b1);
    check("alias_new_pc_predict", pc_predict, 32'h500);

    // ---------------- 32-bit wrap of +4 ----------------
    tick();
    pcf = 32'hFFFF_FFFC;
    #1;
    check("wrap_pc_predict", pc_predict, 32'h0);
    set_upd(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h10);
    #1;
    check("wrap_mispredict", mispredict, 1'b1);
    check("wrap_pc_recover", pc_recover, 32'h0);
    tick();                                     // upd 11: mis, no table change
    idle();
    #1;
    check("miss_nt_no_alloc", pre_br, 1'b0);

    // Miss not-taken on an occupied index must not disturb the entry.
    set_upd(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h44);
    tick();                                     // upd 12
    idle();
    pcf = 32'h80;
    #1;
    check("miss_nt_keeps_entry", pc_predict, 32'h500);
`ifdef BTB_PERF_CNT_EN
    check("perf_branches", perf_branches, 32'd12);
    check("perf_mispred", perf_mispred, 32'd8);
    check("perf_alloc", perf_alloc, 32'd2);
`endif

    // ---------------- asynchronous reset mid-cycle ----------------
    tick();
    pcf = 32'h80;
    #1;
    check("pre_async_pre_br", pre_br, 1'b1);
    set_upd(1'b1, 32'h80, 1'b1, 32'h600, 1'b0, 32'h84);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_pre_br", pre_br, 1'b0);
    check("async_pc_predict", pc_predict, 32'h84);
    check("async_mispredict", mispredict, 1'b0);
`ifdef BTB_PERF_CNT_EN
    check("async_perf_branches", perf_branches, 32'd0);
    check("async_perf_mispred", perf_mispred, 32'd0);
    check("async_perf_alloc", perf_alloc, 32'd0);
`endif
    @(posedge clk);                             // in-flight update discarded
    #2;
    idle();
    rst_n = 1'b1;
    #1;
    check("post_rst_80_pre_br", pre_br, 1'b0);
    check("post_rst_80_pc_predict", pc_predict, 32'h84);
    pcf = 32'h40;
    #1;
    check("post_rst_40_pc_predict", pc_predict, 32'h44);
`ifdef BTB_PERF_CNT_EN
    check("post_rst_perf_branches", perf_branches, 32'd0);
`endif

    // Allocation after reset starts at weak taken.
    tick();
    set_upd(1'b1, 32'h40, 1'b1, 32'h700, 1'b0, 32'h44);
    tick();
    idle();
    #1;
    check("post_rst_alloc_pre_br", pre_br, 1'b1);
    check("post_rst_alloc_target", pc_predict, 32'h700);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard time limit in case anything stalls.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
